// File: rtl/sb_pkg.sv
// Shared sideband definitions for the transmit and receive transaction FSMs.
// Contents: framing byte constants, the frame-state enum, the request-kind
// enum and small helpers.
//   sym(b)      : 10-bit line symbol {stop=1, b, start=0}
//   clse(lse)   : complementary link-state byte (bitwise inverse)
//   is_frame(st): state presents a symbol on the sideband
package sb_pkg;

  localparam logic [7:0]  DLE          = 8'hFE;
  localparam logic [7:0]  STX_CMD      = 8'h05;
  localparam logic [7:0]  STX_RSP      = 8'h04;
  localparam logic [7:0]  ETX          = 8'h40;
  localparam logic [7:0]  LSE_DEFAULT  = 8'h80;
  localparam logic [9:0]  SYM_IDLE     = 10'h3FF;
  // 0x8005 bit-reversed, for the LSB-first CRC-16 shift.
  localparam logic [15:0] CRC_POLY_REF = 16'hA001;

  typedef enum logic [3:0] {
    S_DISCONNECT, S_IDLE, S_DLE_S, S_STX, S_ADDR, S_LEN, S_DATA,
    S_CRC_LO, S_CRC_HI, S_DLE_E, S_ETX, S_LSE, S_CLSE, S_STUFF
  } sb_state_e;

  typedef enum logic [1:0] {K_LT, K_RSP, K_CMD} tx_kind_e;

  function automatic logic [7:0] clse(input logic [7:0] lse);
    return ~lse;
  endfunction

  function automatic logic [9:0] sym(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  function automatic logic is_frame(input sb_state_e st);
    return !(st inside {S_DISCONNECT, S_IDLE});
  endfunction

endpackage

// File: rtl/sb_transactions_tx_if.sv
// Request and symbol bus of the sideband transaction transmitter.
//   master : requester + serializer side (drives requests, fields, sym_ready)
//   slave  : transmitter side (drives req_ack, sbtx, sbtx_valid)
// Handshakes:
//   request : a requester holds *_req and the t_* / payload fields stable
//             until it sees req_ack; req_ack is a one-cycle pulse.
//   symbol  : a symbol transfers on a cycle with sbtx_valid & sym_ready;
//             while sym_ready is low sbtx and sbtx_valid are held stable.
interface sb_transactions_tx_if #(
  parameter int MAX_DATA = 3
);
  logic                  at_cmd_req;
  logic                  at_rsp_req;
  logic                  lt_req;
  logic [7:0]            t_address;
  logic                  t_write;
  logic [6:0]            t_len;
  logic [8*MAX_DATA-1:0] payload_out;
  logic                  req_ack;
  logic [9:0]            sbtx;
  logic                  sbtx_valid;
  logic                  sym_ready;

  modport master (
    output at_cmd_req, at_rsp_req, lt_req, t_address, t_write, t_len,
           payload_out, sym_ready,
    input  req_ack, sbtx, sbtx_valid
  );

  modport slave (
    input  at_cmd_req, at_rsp_req, lt_req, t_address, t_write, t_len,
           payload_out, sym_ready,
    output req_ack, sbtx, sbtx_valid
  );
endinterface

// File: rtl/sb_crc16.sv
// Byte-wide CRC-16 (poly 0x8005, reflected, no final XOR) with seed/enable
// register. Shared with the receive-side CRC checker.
//   sb_clk, rst : clock, asynchronous active-low reset (crc <= CRC_INIT)
//   init        : load CRC_INIT (priority over en)
//   en, data    : fold one byte into the running CRC
//   crc         : registered CRC value
//   crc_d       : value crc takes at the next edge
module sb_crc16
  import sb_pkg::*;
#(
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic        sb_clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc,
  output logic [15:0] crc_d
);

  function automatic logic [15:0] crc16_next(input logic [15:0] c,
                                             input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY_REF) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    crc_d = crc;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = crc16_next(crc, data);
    end
  end

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      crc <= CRC_INIT;
    end else begin
      crc <= crc_d;
    end
  end

endmodule

// File: rtl/sb_transactions_tx.sv
// Sideband transaction transmitter: frames AT commands, AT responses and LT
// transactions into 10-bit sideband symbols with DLE stuffing and CRC-16.
//   sb_clk, rst  : clock, asynchronous active-low reset
//   tconnect     : leave DISCONNECT for IDLE
//   tdisconnect  : drop any frame, go to DISCONNECT (highest priority)
//   bus          : request fields/req_ack and symbol stream (slave side)
//   busy         : frame in progress (from the req_ack cycle on)
//   done         : one-cycle pulse after ETX / CLSE is accepted
//   disconnect   : high while in DISCONNECT
//   state_dbg    : current FSM state
// All outputs are registered: sbtx is loaded with the symbol of the state
// being entered, so it always matches the state register.
module sb_transactions_tx
  import sb_pkg::*;
#(
  parameter int          MAX_DATA   = 3,
  parameter logic [7:0]  LSE_SYMBOL = LSE_DEFAULT,
  parameter logic [15:0] CRC_INIT   = 16'hFFFF
) (
  input  logic               sb_clk,
  input  logic               rst,
  input  logic               tconnect,
  input  logic               tdisconnect,
  sb_transactions_tx_if.slave bus,
  output logic               busy,
  output logic               done,
  output logic               disconnect,
  output sb_state_e          state_dbg
);

  localparam int             CW    = $clog2(MAX_DATA + 1);
  localparam logic [CW-1:0]  N_MAX = CW'(MAX_DATA);

  sb_state_e             state, state_n, resume, resume_n, after_st;
  tx_kind_e              kind, kind_n;
  logic [7:0]            cap_addr;
  logic                  cap_write;
  logic [CW-1:0]         cap_n, n_sat, cnt, cnt_n;
  logic [8*MAX_DATA-1:0] cap_data;
  logic                  has_data, has_data_n;
  logic                  accept, ack_n, done_n, crc_en, stuffable, adv;
  logic [7:0]            cur_byte, nxt_byte;
  logic [15:0]           crc_q, crc_d;

  assign state_dbg = state;

  function automatic logic [7:0] byte_for(input sb_state_e st,
                                          input logic [CW-1:0] idx,
                                          input logic [15:0] c);
    case (st)
      S_STX:    return (kind == K_CMD) ? STX_CMD : STX_RSP;
      S_ADDR:   return cap_addr;
      S_LEN:    return {cap_write, 7'(cap_n)};
      S_DATA:   return 8'(cap_data >> {idx, 3'b000});
      S_CRC_LO: return c[7:0];
      S_CRC_HI: return c[15:8];
      S_ETX:    return ETX;
      S_LSE:    return LSE_SYMBOL;
      S_CLSE:   return clse(LSE_SYMBOL);
      default:  return DLE;
    endcase
  endfunction

  assign cur_byte = byte_for(state, cnt, crc_q);
  assign nxt_byte = byte_for(state_n, cnt_n, crc_d);
  assign n_sat    = (bus.t_len > 7'(MAX_DATA)) ? N_MAX : bus.t_len[CW-1:0];
  assign has_data_n = (kind_n == K_CMD && bus.t_write) ||
                      (kind_n == K_RSP && !bus.t_write);

  sb_crc16 #(.CRC_INIT(CRC_INIT)) u_crc (
    .sb_clk (sb_clk),
    .rst    (rst),
    .init   (accept),
    .en     (crc_en),
    .data   (cur_byte),
    .crc    (crc_q),
    .crc_d  (crc_d)
  );

  always_comb begin
    state_n   = state;
    resume_n  = resume;
    after_st  = state;
    cnt_n     = cnt;
    kind_n    = kind;
    accept    = 1'b0;
    ack_n     = 1'b0;
    done_n    = 1'b0;
    crc_en    = 1'b0;
    stuffable = 1'b0;
    adv       = bus.sbtx_valid & bus.sym_ready;
    case (state)
      S_DISCONNECT: if (tconnect) state_n = S_IDLE;
      S_IDLE: begin
        // The req_ack cycle is spent in IDLE so the DLE follows it; the
        // still-held request must not be accepted a second time.
        if (bus.req_ack) begin
          state_n = S_DLE_S;
        end else if (bus.lt_req | bus.at_rsp_req | bus.at_cmd_req) begin
          accept = 1'b1;
          ack_n  = 1'b1;
          if (bus.lt_req)          kind_n = K_LT;
          else if (bus.at_rsp_req) kind_n = K_RSP;
          else                     kind_n = K_CMD;
        end
      end
      S_DLE_S:  if (adv) state_n = (kind == K_LT) ? S_LSE : S_STX;
      S_STX: if (adv) begin
        crc_en  = 1'b1;
        state_n = S_ADDR;
      end
      S_ADDR: if (adv) begin
        crc_en    = 1'b1;
        stuffable = 1'b1;
        after_st  = S_LEN;
      end
      S_LEN: if (adv) begin
        crc_en    = 1'b1;
        stuffable = 1'b1;
        after_st  = (has_data && cap_n != '0) ? S_DATA : S_CRC_LO;
      end
      S_DATA: if (adv) begin
        crc_en    = 1'b1;
        stuffable = 1'b1;
        cnt_n     = cnt + 1'b1;
        after_st  = (cnt_n == cap_n) ? S_CRC_LO : S_DATA;
      end
      S_CRC_LO: if (adv) begin
        stuffable = 1'b1;
        after_st  = S_CRC_HI;
      end
      S_CRC_HI: if (adv) begin
        stuffable = 1'b1;
        after_st  = S_DLE_E;
      end
      S_DLE_E:  if (adv) state_n = S_ETX;
      S_ETX, S_CLSE: if (adv) begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
      S_LSE:    if (adv) state_n = S_CLSE;
      S_STUFF:  if (adv) state_n = resume;
      default:  state_n = S_DISCONNECT;
    endcase
    // A body byte equal to DLE is followed by a second DLE before moving on.
    if (stuffable) begin
      resume_n = after_st;
      state_n  = (cur_byte == DLE) ? S_STUFF : after_st;
    end
    if (tdisconnect) begin
      state_n = S_DISCONNECT;
      accept  = 1'b0;
      ack_n   = 1'b0;
      done_n  = 1'b0;
      crc_en  = 1'b0;
    end
  end

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      state          <= S_DISCONNECT;
      resume         <= S_DISCONNECT;
      kind           <= K_LT;
      cap_addr       <= '0;
      cap_write      <= 1'b0;
      cap_n          <= '0;
      cap_data       <= '0;
      has_data       <= 1'b0;
      cnt            <= '0;
      bus.req_ack    <= 1'b0;
      bus.sbtx       <= SYM_IDLE;
      bus.sbtx_valid <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      disconnect     <= 1'b1;
    end else begin
      state  <= state_n;
      resume <= resume_n;
      cnt    <= accept ? '0 : cnt_n;
      if (accept) begin
        kind      <= kind_n;
        cap_addr  <= bus.t_address;
        cap_write <= bus.t_write;
        cap_n     <= n_sat;
        cap_data  <= bus.payload_out;
        has_data  <= has_data_n;
      end
      bus.req_ack    <= ack_n;
      bus.sbtx_valid <= is_frame(state_n);
      bus.sbtx       <= is_frame(state_n) ? sym(nxt_byte) : SYM_IDLE;
      busy           <= is_frame(state_n) || ack_n;
      done           <= done_n;
      disconnect     <= (state_n == S_DISCONNECT);
    end
  end

endmodule

// File: tb/tb_sb_transactions_tx.sv
// Self-checking bench for sb_transactions_tx. A reference model builds the
// expected symbol stream of each frame from the framing rules (byte list,
// bit-serial CRC over unstuffed bytes, DLE stuffing) into exp_q; the symbol
// collector pops it on every accepted symbol.
module tb_sb_transactions_tx;
  import sb_pkg::*;

  localparam int MAX_DATA = 3;

  logic      sb_clk = 1'b0;
  logic      rst;
  logic      tconnect;
  logic      tdisconnect;
  logic      busy;
  logic      done;
  logic      disconnect;
  sb_state_e state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] exp_q[$];

  sb_transactions_tx_if #(.MAX_DATA(MAX_DATA)) bus ();

  sb_transactions_tx #(.MAX_DATA(MAX_DATA)) dut (
    .sb_clk      (sb_clk),
    .rst         (rst),
    .tconnect    (tconnect),
    .tdisconnect (tdisconnect),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .disconnect  (disconnect),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 sb_clk = ~sb_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [9:0] to_sym(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // CRC-16, poly 0x8005 reflected, one message bit at a time, LSB first.
  function automatic logic [15:0] crc_model(input logic [7:0] q[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        logic fb;
        fb = c[0] ^ q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  function automatic void build_lt();
    exp_q.push_back(to_sym(8'hFE));
    exp_q.push_back(to_sym(8'h80));
    exp_q.push_back(to_sym(8'h7F));
  endfunction

  function automatic void build_at(input bit is_rsp, input logic [7:0] addr,
                                   input logic wr, input logic [6:0] len,
                                   input logic [23:0] pl);
    int n;
    logic [7:0] body[$];
    logic [15:0] c;
    n = (int'(len) > MAX_DATA) ? MAX_DATA : int'(len);
    body.push_back(is_rsp ? 8'h04 : 8'h05);
    body.push_back(addr);
    body.push_back({wr, 7'(n)});
    if ((!is_rsp && wr) || (is_rsp && !wr)) begin
      for (int i = 0; i < n; i++) body.push_back(pl[8*i +: 8]);
    end
    c = crc_model(body);
    body.push_back(c[7:0]);
    body.push_back(c[15:8]);
    exp_q.push_back(to_sym(8'hFE));
    foreach (body[i]) begin
      exp_q.push_back(to_sym(body[i]));
      if (i > 0 && body[i] == 8'hFE) exp_q.push_back(to_sym(8'hFE));
    end
    exp_q.push_back(to_sym(8'hFE));
    exp_q.push_back(to_sym(8'h40));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_reqs();
    bus.lt_req     = 1'b0;
    bus.at_rsp_req = 1'b0;
    bus.at_cmd_req = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns in the req_ack cycle.
  task automatic send_req(input string name, input int kind,
                          input logic [7:0] addr, input logic wr,
                          input logic [6:0] len, input logic [23:0] pl);
    int w = 0;
    bus.t_address   = addr;
    bus.t_write     = wr;
    bus.t_len       = len;
    bus.payload_out = pl;
    bus.lt_req      = (kind == 0);
    bus.at_rsp_req  = (kind == 1);
    bus.at_cmd_req  = (kind == 2);
    do begin
      @(negedge sb_clk);
      w++;
    end while (bus.req_ack !== 1'b1 && w < 10);
    clear_reqs();
    // Captured fields must no longer matter.
    bus.t_address   = 8'($urandom);
    bus.t_write     = 1'($urandom);
    bus.t_len       = 7'($urandom);
    bus.payload_out = 24'($urandom);
    n_checks++;
    if (bus.req_ack !== 1'b1 || w != 1 || bus.sbtx !== 10'h3FF ||
        bus.sbtx_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s req_ack: ack=%b after %0d cycles sbtx=%h valid=%b busy=%b, need ack=1 after 1 cycle sbtx=3ff valid=0 busy=1",
               name, bus.req_ack, w, bus.sbtx, bus.sbtx_valid, busy);
    end
  endtask

  // Consumes exp_q symbol by symbol. stall_idx: hold sym_ready low for 4
  // cycles on that symbol. stop_after >= 0: return at the negedge where
  // that many symbols have been accepted (frame left running).
  task automatic collect(input string name, input bit rnd,
                         input int stall_idx, input int stop_after);
    int acc = 0;
    int stall = 0;
    int cyc = 0;
    logic [9:0] prev = '0;
    bit held = 1'b0;
    while (exp_q.size() != 0 && cyc < 500) begin
      @(negedge sb_clk);
      cyc++;
      if (stop_after >= 0 && acc == stop_after) begin
        bus.sym_ready = 1'b0;
        return;
      end
      n_checks++;
      if (bus.sbtx_valid !== 1'b1 || bus.req_ack !== 1'b0 ||
          done !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s frame_ctl: idx %0d valid=%b ack=%b done=%b busy=%b, need 1 0 0 1",
                 name, acc, bus.sbtx_valid, bus.req_ack, done, busy);
      end
      if (held) begin
        n_checks++;
        if (bus.sbtx !== prev) begin
          n_fail++;
          $display("FAIL %s hold: idx %0d sbtx=%h, held symbol %h", name, acc, bus.sbtx, prev);
        end
      end
      if (stall_idx == acc && stall < 4) begin
        bus.sym_ready = 1'b0;
        stall++;
      end else if (rnd) begin
        bus.sym_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.sym_ready = 1'b1;
      end
      prev = bus.sbtx;
      held = !bus.sym_ready;
      if (bus.sym_ready) begin
        n_checks++;
        if (bus.sbtx !== exp_q[0]) begin
          n_fail++;
          $display("FAIL %s sym: idx %0d sbtx=%h expected %h", name, acc, bus.sbtx, exp_q[0]);
        end
        void'(exp_q.pop_front());
        acc++;
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s timeout: %0d symbols still expected after %0d cycles", name, exp_q.size(), cyc);
      exp_q.delete();
    end
    if (stop_after < 0) begin
      @(negedge sb_clk);
      bus.sym_ready = 1'b0;
      n_checks++;
      if (done !== 1'b1 || bus.sbtx !== 10'h3FF || bus.sbtx_valid !== 1'b0 ||
          busy !== 1'b0 || disconnect !== 1'b0) begin
        n_fail++;
        $display("FAIL %s end: done=%b sbtx=%h valid=%b busy=%b disc=%b, need 1 3ff 0 0 0",
                 name, done, bus.sbtx, bus.sbtx_valid, busy, disconnect);
      end
    end
  endtask

  task automatic check_dropped(input string name);
    n_checks++;
    if (bus.sbtx !== 10'h3FF || bus.sbtx_valid !== 1'b0 || disconnect !== 1'b1 ||
        done !== 1'b0 || busy !== 1'b0 || bus.req_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL %s dropped: sbtx=%h valid=%b disc=%b done=%b busy=%b ack=%b, need 3ff 0 1 0 0 0",
               name, bus.sbtx, bus.sbtx_valid, disconnect, done, busy, bus.req_ack);
    end
  endtask

  task automatic reconnect(input string name);
    @(negedge sb_clk);
    n_checks++;
    if (disconnect !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s reconnect: disc=%b done=%b, need 0 0", name, disconnect, done);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    tconnect = 1'b0;
    tdisconnect = 1'b0;
    clear_reqs();
    bus.t_address = '0;
    bus.t_write = 1'b0;
    bus.t_len = '0;
    bus.payload_out = '0;
    bus.sym_ready = 1'b0;
    repeat (3) @(negedge sb_clk);
    check_dropped("reset");
    n_checks++;
    if (state_dbg !== S_DISCONNECT) begin
      n_fail++;
      $display("FAIL reset state: state_dbg=%0d, need DISCONNECT", state_dbg);
    end
    rst = 1'b1;
    bus.lt_req = 1'b1;
    repeat (3) @(negedge sb_clk);
    check_dropped("disc_ignores_req");
    bus.lt_req = 1'b0;
    tconnect = 1'b1;
    reconnect("connect");
  endtask

  task automatic test_lt();
    build_lt();
    send_req("lt", 0, 8'h00, 1'b0, 7'd0, 24'h0);
    collect("lt", 1'b0, -1, -1);
  endtask

  task automatic test_read_cmd();
    build_at(1'b0, 8'h12, 1'b0, 7'd3, 24'h0);
    send_req("read_cmd", 2, 8'h12, 1'b0, 7'd3, 24'h0);
    collect("read_cmd", 1'b0, -1, -1);
  endtask

  task automatic test_read_rsp();
    build_at(1'b1, 8'h34, 1'b0, 7'd3, 24'hCCBBAA);
    send_req("read_rsp", 1, 8'h34, 1'b0, 7'd3, 24'hCCBBAA);
    collect("read_rsp", 1'b0, -1, -1);
    build_at(1'b1, 8'h35, 1'b0, 7'd9, 24'h332211);
    send_req("rsp_len_sat", 1, 8'h35, 1'b0, 7'd9, 24'h332211);
    collect("rsp_len_sat", 1'b0, -1, -1);
  endtask

  task automatic test_stuffing();
    logic [23:0] pl;
    pl = {16'h5A69, 8'hFE};
    build_at(1'b0, 8'hFE, 1'b1, 7'd3, pl);
    send_req("stuffing", 2, 8'hFE, 1'b1, 7'd3, pl);
    collect("stuffing", 1'b0, -1, -1);
  endtask

  task automatic test_backpressure();
    logic [23:0] pl;
    pl = 24'($urandom);
    build_at(1'b0, 8'h47, 1'b1, 7'd2, pl);
    send_req("backpressure", 2, 8'h47, 1'b1, 7'd2, pl);
    collect("backpressure", 1'b0, 2, -1);
  endtask

  task automatic test_priority();
    logic [23:0] pl;
    int w = 0;
    pl = 24'($urandom);
    build_lt();
    bus.t_address = 8'hA5;
    bus.t_write = 1'b1;
    bus.t_len = 7'd2;
    bus.payload_out = pl;
    bus.lt_req = 1'b1;
    bus.at_cmd_req = 1'b1;
    do begin
      @(negedge sb_clk);
      w++;
    end while (bus.req_ack !== 1'b1 && w < 10);
    bus.lt_req = 1'b0;
    n_checks++;
    if (bus.req_ack !== 1'b1 || w != 1) begin
      n_fail++;
      $display("FAIL prio first_ack: ack=%b after %0d cycles, need 1 after 1", bus.req_ack, w);
    end
    collect("prio_lt", 1'b0, -1, -1);
    @(negedge sb_clk);
    n_checks++;
    if (bus.req_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL prio second_ack: ack=%b in cycle after done, need 1", bus.req_ack);
    end
    bus.at_cmd_req = 1'b0;
    build_at(1'b0, 8'hA5, 1'b1, 7'd2, pl);
    collect("prio_cmd", 1'b0, -1, -1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      int kind;
      logic [7:0] addr;
      logic wr;
      logic [6:0] len;
      logic [23:0] pl;
      kind = $urandom_range(0, 2);
      addr = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      wr   = 1'($urandom);
      len  = 7'($urandom_range(0, 9));
      pl   = 24'($urandom);
      if ($urandom_range(0, 2) == 0) pl[15:8] = 8'hFE;
      if (kind == 0) build_lt();
      else build_at(kind == 1, addr, wr, len, pl);
      send_req("random", kind, addr, wr, len, pl);
      collect("random", 1'b1, -1, -1);
      repeat ($urandom_range(0, 2)) @(negedge sb_clk);
    end
  endtask

  task automatic test_abort();
    logic [23:0] pl;
    pl = 24'h112233;
    build_at(1'b0, 8'h33, 1'b1, 7'd3, pl);
    send_req("abort", 2, 8'h33, 1'b1, 7'd3, pl);
    collect("abort", 1'b0, -1, 4);
    tdisconnect = 1'b1;
    @(negedge sb_clk);
    tdisconnect = 1'b0;
    exp_q.delete();
    check_dropped("abort");
    n_checks++;
    if (state_dbg !== S_DISCONNECT) begin
      n_fail++;
      $display("FAIL abort state: state_dbg=%0d, need DISCONNECT", state_dbg);
    end
    reconnect("abort");
  endtask

  task automatic test_async_reset();
    logic [23:0] pl;
    pl = 24'h0A0B0C;
    build_at(1'b1, 8'h21, 1'b0, 7'd3, pl);
    send_req("async_rst", 1, 8'h21, 1'b0, 7'd3, pl);
    collect("async_rst", 1'b0, -1, 3);
    #2;
    rst = 1'b0;
    #1;
    exp_q.delete();
    check_dropped("async_rst");
    @(negedge sb_clk);
    rst = 1'b1;
    reconnect("async_rst");
    build_lt();
    send_req("after_rst", 0, 8'h00, 1'b0, 7'd0, 24'h0);
    collect("after_rst", 1'b0, -1, -1);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_lt();
    test_read_cmd();
    test_read_rsp();
    test_stuffing();
    test_backpressure();
    test_priority();
    test_random();
    test_abort();
    test_async_reset();
    repeat (2) @(negedge sb_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
